// File: rtl/serpent_dec_iter.sv
// Iterative Serpent-128 decryption core: one inverse round per clock, subkeys K32..K0
// fetched from an external combinational key store through key_idx/key_in.
module serpent_dec_iter #(
  parameter int NUM_ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [5:0]   key_idx,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [5:0] CNT_FIRST = 6'(NUM_ROUNDS);
  localparam logic [5:0] CNT_SBOX_ONLY = 6'(NUM_ROUNDS - 1);

  localparam logic [3:0] INV_SBOX [8][16] = '{
    '{4'hD, 4'h3, 4'hB, 4'h0, 4'hA, 4'h6, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hF, 4'h9, 4'h8, 4'h2},
    '{4'h5, 4'h8, 4'h2, 4'hE, 4'hF, 4'h6, 4'hC, 4'h3, 4'hB, 4'h4, 4'h7, 4'h9, 4'h1, 4'hD, 4'hA, 4'h0},
    '{4'hC, 4'h9, 4'hF, 4'h4, 4'hB, 4'hE, 4'h1, 4'h2, 4'h0, 4'h3, 4'h6, 4'hD, 4'h5, 4'h8, 4'hA, 4'h7},
    '{4'h0, 4'h9, 4'hA, 4'h7, 4'hB, 4'hE, 4'h6, 4'hD, 4'h3, 4'h5, 4'hC, 4'h2, 4'h4, 4'h8, 4'hF, 4'h1},
    '{4'h5, 4'h0, 4'h8, 4'h3, 4'hA, 4'h9, 4'h7, 4'hE, 4'h2, 4'hC, 4'hB, 4'h6, 4'h4, 4'hF, 4'hD, 4'h1},
    '{4'h8, 4'hF, 4'h2, 4'h9, 4'h4, 4'h1, 4'hD, 4'hE, 4'hB, 4'h6, 4'h5, 4'h3, 4'h7, 4'hC, 4'hA, 4'h0},
    '{4'hF, 4'hA, 4'h1, 4'hD, 4'h5, 4'h3, 4'h6, 4'h0, 4'h4, 4'h9, 4'hE, 4'h7, 4'h2, 4'hC, 4'h8, 4'hB},
    '{4'h3, 4'h0, 4'h6, 4'hD, 4'h9, 4'hE, 4'hF, 4'h8, 4'h5, 4'hC, 4'hB, 4'h7, 4'hA, 4'h1, 4'h4, 4'h2}
  };

  fsm_t         fsm_q, fsm_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;

  logic [127:0] lt_out;
  logic [127:0] sbox_in;
  logic [127:0] sbox_out;
  logic [127:0] round_out;
  logic [2:0]   box_sel;

  function automatic logic [127:0] inv_lt(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    x0 = x[31:0];
    x1 = x[63:32];
    x2 = x[95:64];
    x3 = x[127:96];
    x2 = {x2[21:0], x2[31:22]};
    x0 = {x0[4:0], x0[31:5]};
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = {x3[6:0], x3[31:7]};
    x1 = {x1[0], x1[31:1]};
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = {x2[2:0], x2[31:3]};
    x0 = {x0[12:0], x0[31:13]};
    return {x3, x2, x1, x0};
  endfunction

  assign lt_out  = inv_lt(state_q);
  // The first S-box round after the K32 whitening has no linear transform in front of it.
  assign sbox_in = (cnt_q == CNT_SBOX_ONLY) ? state_q : lt_out;
  assign box_sel = cnt_q[2:0];

  for (genvar gi = 0; gi < 32; gi++) begin : g_sbox
    logic [3:0] nib_in;
    logic [3:0] nib_out;
    assign nib_in       = {sbox_in[96+gi], sbox_in[64+gi], sbox_in[32+gi], sbox_in[gi]};
    assign nib_out      = INV_SBOX[box_sel][nib_in];
    assign sbox_out[gi]     = nib_out[0];
    assign sbox_out[32+gi]  = nib_out[1];
    assign sbox_out[64+gi]  = nib_out[2];
    assign sbox_out[96+gi]  = nib_out[3];
  end

  assign round_out = ((cnt_q == CNT_FIRST) ? state_q : sbox_out) ^ key_in;

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          cnt_d   = CNT_FIRST;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_out;
        if (cnt_q == 6'd0) begin
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= 6'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign key_idx   = (fsm_q == RUN) ? cnt_q : 6'd0;
  assign out_data  = state_q;

endmodule

// File: tb/tb_serpent_dec_iter.sv
// Bench for serpent_dec_iter: encrypts with a forward Serpent model and checks the core
// recovers the plaintext, plus handshake, key sequencing, reset and backpressure sequences.
module tb_serpent_dec_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [5:0]   key_idx;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  logic [127:0] rk [33];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [6];

  int SBOX [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  always #5 clk = ~clk;

  // Combinational key store
  assign key_in = (key_idx <= 6'd32) ? rk[key_idx] : '0;

  serpent_dec_iter #(.NUM_ROUNDS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] sbox_layer(input int box, input logic [127:0] x);
    logic [127:0] y;
    int n, v;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      n = {28'd0, x[96+i], x[64+i], x[32+i], x[i]};
      v = SBOX[box][n];
      y[i] = v[0];
      y[32+i] = v[1];
      y[64+i] = v[2];
      y[96+i] = v[3];
    end
    return y;
  endfunction

  function automatic logic [127:0] lt(input logic [127:0] x);
    logic [31:0] a, b, c, d;
    a = x[31:0]; b = x[63:32]; c = x[95:64]; d = x[127:96];
    a = rol(a, 13); c = rol(c, 3);
    b = b ^ a ^ c; d = d ^ c ^ (a << 3);
    b = rol(b, 1); d = rol(d, 7);
    a = a ^ b ^ d; c = c ^ d ^ (b << 7);
    a = rol(a, 5); c = rol(c, 22);
    return {d, c, b, a};
  endfunction

  task automatic make_keys(input logic [127:0] key);
    logic [31:0] w [140];
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    w[4] = 32'd1; w[5] = 32'd0; w[6] = 32'd0; w[7] = 32'd0;
    for (int i = 8; i < 140; i++)
      w[i] = rol(w[i-8] ^ w[i-5] ^ w[i-3] ^ w[i-1] ^ 32'h9e3779b9 ^ 32'(i - 8), 11);
    for (int i = 0; i < 33; i++)
      rk[i] = sbox_layer((35 - i) % 8, {w[8+4*i+3], w[8+4*i+2], w[8+4*i+1], w[8+4*i]});
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] x;
    x = pt;
    for (int r = 0; r < 32; r++) begin
      x = x ^ rk[r];
      x = sbox_layer(r % 8, x);
      if (r < 31) x = lt(x);
      else x = x ^ rk[32];
    end
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full transaction with out_ready high; entered and left on a negedge.
  task automatic xfer(input logic [127:0] ct, input logic [127:0] pt, input string tag);
    int n, lat;
    in_data = ct;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, " accept"}, 128'(in_ready), 128'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, " latency"}, 128'(lat), 128'd33);
    chk({tag, " data"}, out_data, pt);
    $display("xfer %s ct=%h pt=%h got=%h lat=%0d", tag, ct, pt, out_data, lat);
    @(negedge clk);
    chk({tag, " release"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct, pt, ct2, pt2, key;
    logic [127:0] bb_ct [4];
    logic [127:0] exp_q [$];
    longint t_prev;
    int n;
    bit seen;

    vecs[0] = '{key: 128'h0, pt: 128'h0};
    vecs[1] = '{key: 128'h000102030405060708090A0B0C0D0E0F, pt: 128'h00112233445566778899AABBCCDDEEFF};
    vecs[2] = '{key: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, pt: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};
    for (int i = 3; i < 6; i++) vecs[i] = '{key: rand128(), pt: rand128()};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", 128'(in_ready), 128'd1);
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst key_idx", 128'(key_idx), 128'd0);
    rst = 1'b0;

    // Key sequencing and exact latency on the pattern vector
    make_keys(vecs[1].key);
    ct = encrypt(vecs[1].pt);
    chk("idle key_idx", 128'(key_idx), 128'd0);
    in_data = ct;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 33; k++) begin
      chk($sformatf("key_idx step %0d", k), 128'(key_idx), 128'(32 - k));
      chk($sformatf("early out_valid step %0d", k), 128'(out_valid), 128'd0);
      @(negedge clk);
    end
    chk("keyseq out_valid", 128'(out_valid), 128'd1);
    chk("keyseq data", out_data, vecs[1].pt);
    $display("xfer keyseq ct=%h pt=%h got=%h", ct, vecs[1].pt, out_data);
    @(negedge clk);
    chk("keyseq release", 128'(out_valid), 128'd0);
    chk("keyseq idle", 128'(in_ready), 128'd1);

    // Table of round-trip vectors
    for (int i = 0; i < 6; i++) begin
      make_keys(vecs[i].key);
      xfer(encrypt(vecs[i].pt), vecs[i].pt, $sformatf("vec%0d", i));
    end

    // Reset mid-RUN at cnt=15 aborts the block
    key = rand128();
    make_keys(key);
    pt = rand128();
    ct = encrypt(pt);
    in_data = ct;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (key_idx != 6'd15 && n < 50) begin @(negedge clk); n++; end
    chk("reach cnt15", 128'(key_idx), 128'd15);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", 128'(in_ready), 128'd1);
    chk("abort out_valid", 128'(out_valid), 128'd0);
    chk("abort key_idx", 128'(key_idx), 128'd0);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("no output after abort", 128'(seen), 128'd0);
    xfer(ct, pt, "after_abort");

    // Reset while holding a result in DONE
    out_ready = 1'b0;
    in_data = ct;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("done reached", 128'(out_valid), 128'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("done rst out_valid", 128'(out_valid), 128'd0);
    chk("done rst in_ready", 128'(in_ready), 128'd1);

    // Backpressure in DONE with a new block waiting
    pt = rand128();  ct = encrypt(pt);
    pt2 = rand128(); ct2 = encrypt(pt2);
    out_ready = 1'b0;
    in_data = ct;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = ct2;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp data %0d", k), out_data, pt);
      chk($sformatf("bp in_ready %0d", k), 128'(in_ready), 128'd0);
      chk($sformatf("bp out_valid %0d", k), 128'(out_valid), 128'd1);
      @(negedge clk);
    end
    $display("xfer backpressure pt=%h got=%h", pt, out_data);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", 128'(out_valid), 128'd0);
    chk("bp release in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    chk("bp second accept", 128'(key_idx), 128'd32);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp second data", out_data, pt2);
    $display("xfer backpressure2 pt=%h got=%h", pt2, out_data);
    @(negedge clk);

    // Back-to-back blocks with both handshakes held high
    for (int j = 0; j < 4; j++) begin
      pt = rand128();
      bb_ct[j] = encrypt(pt);
      exp_q.push_back(pt);
    end
    out_ready = 1'b1;
    t_prev = 0;
    fork
      begin
        int dn;
        for (int j = 0; j < 4; j++) begin
          in_data = bb_ct[j];
          in_valid = 1'b1;
          dn = 0;
          while (!in_ready && dn < 200) begin @(negedge clk); dn++; end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int mn;
        longint t_now;
        logic [127:0] want;
        for (int j = 0; j < 4; j++) begin
          mn = 0;
          while (!out_valid && mn < 200) begin @(negedge clk); mn++; end
          want = exp_q.pop_front();
          chk($sformatf("b2b data %0d", j), out_data, want);
          t_now = longint'($time);
          if (j > 0) chk($sformatf("b2b spacing %0d", j), 128'((t_now - t_prev) / 10), 128'd35);
          t_prev = t_now;
          $display("xfer b2b%0d pt=%h got=%h t=%0d", j, want, out_data, t_now);
          @(negedge clk);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
